psum_shift_accumulator: RTL and testbench

- Sits directly downstream of the XNOR PE array and consumes the registered signed partial sum the PE emits every cycle.
- Aligns each partial sum by a per-beat left shift (bit-brick significance) and accumulates a group of beats into a wide signed accumulator.
- Hands the finished group result to the output/requant stage through a one-entry valid/ready output buffer.

---
 rtl/psum_shift_accumulator.sv | 133 +++++++++++++
 tb/tb_psum_shift_accumulator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/psum_shift_accumulator.sv
// Shift-align and accumulate signed PE partial sums into saturating group results,
// delivered through a one-entry valid/ready output buffer.
`ifndef BITS_SIP_DOT_ADDER
`define BITS_SIP_DOT_ADDER 8
`endif

module psum_shift_accumulator #(
  parameter int PSUM_W  = `BITS_SIP_DOT_ADDER,
  parameter int SHIFT_W = 4,
  parameter int ACC_W   = 24,
  parameter int CNT_W   = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [PSUM_W-1:0]  i_psum,
  input  logic               i_valid,
  output logic               o_in_ready,
  input  logic [SHIFT_W-1:0] i_shift,
  input  logic               i_first,
  input  logic               i_last,
  output logic [ACC_W-1:0]   o_result,
  output logic               o_valid,
  input  logic               i_out_ready,
  output logic [CNT_W-1:0]   o_count,
  output logic               o_sat,
  output logic               o_err
);

  // state | meaning
  // IDLE  | no open group
  // ACC   | group open, acc_q holds the running sum
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACC  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_g_q, sat_g_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;
  logic             osat_q, osat_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic             acc_en, grp_start, sat_hi, sat_lo, sat_beat, sat_next;
  logic [ACC_W:0]   term;
  logic [ACC_W+1:0] base, sum;
  logic [ACC_W-1:0] clamped;
  logic [CNT_W-1:0] cnt_next;

  assign o_in_ready = !valid_q || i_out_ready;
  assign acc_en     = i_valid && o_in_ready;
  assign grp_start  = i_first || (state_q == S_IDLE);

  always_comb begin
    term = {{(ACC_W+1-PSUM_W){i_psum[PSUM_W-1]}}, i_psum} << i_shift;
    base = grp_start ? '0 : {{2{acc_q[ACC_W-1]}}, acc_q};
    sum  = base + {term[ACC_W], term};
    // In range exactly when the top three bits of the wide sum agree
    sat_hi   = !sum[ACC_W+1] && (sum[ACC_W:ACC_W-1] != 2'b00);
    sat_lo   =  sum[ACC_W+1] && (sum[ACC_W:ACC_W-1] != 2'b11);
    sat_beat = sat_hi || sat_lo;
    if (sat_hi)      clamped = {1'b0, {(ACC_W-1){1'b1}}};
    else if (sat_lo) clamped = {1'b1, {(ACC_W-1){1'b0}}};
    else             clamped = sum[ACC_W-1:0];
    sat_next = (grp_start ? 1'b0 : sat_g_q) | sat_beat;
    if (grp_start)          cnt_next = CNT_W'(1);
    else if (&cnt_q)        cnt_next = cnt_q;
    else                    cnt_next = cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sat_g_d  = sat_g_q;
    result_d = result_q;
    ocnt_d   = ocnt_q;
    osat_d   = osat_q;
    valid_d  = valid_q;
    err_d    = 1'b0;
    if (valid_q && i_out_ready) valid_d = 1'b0;
    if (acc_en) begin
      err_d = i_first ? (state_q == S_ACC) : (state_q == S_IDLE);
      if (i_last) begin
        result_d = clamped;
        ocnt_d   = cnt_next;
        osat_d   = sat_next;
        valid_d  = 1'b1;
        acc_d    = '0;
        cnt_d    = '0;
        sat_g_d  = 1'b0;
        state_d  = S_IDLE;
      end else begin
        acc_d    = clamped;
        cnt_d    = cnt_next;
        sat_g_d  = sat_next;
        state_d  = S_ACC;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      sat_g_q  <= 1'b0;
      result_q <= '0;
      ocnt_q   <= '0;
      osat_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sat_g_q  <= sat_g_d;
      result_q <= result_d;
      ocnt_q   <= ocnt_d;
      osat_q   <= osat_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign o_result = result_q;
  assign o_count  = ocnt_q;
  assign o_sat    = osat_q;
  assign o_valid  = valid_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_psum_shift_accumulator.sv
// Bench for psum_shift_accumulator: directed scenarios with literal expectations plus
// a randomized run checked against an arithmetic group/buffer model.
module tb_psum_shift_accumulator;
  localparam int PSUM_W = 8, SHIFT_W = 4, ACC_W = 12, CNT_W = 8;

  logic                     CLK = 1'b0;
  logic                     RST = 1'b0;
  logic signed [PSUM_W-1:0] i_psum = '0;
  logic                     i_valid = 1'b0;
  logic                     o_in_ready;
  logic [SHIFT_W-1:0]       i_shift = '0;
  logic                     i_first = 1'b0;
  logic                     i_last = 1'b0;
  logic [ACC_W-1:0]         o_result;
  logic                     o_valid;
  logic                     i_out_ready = 1'b1;
  logic [CNT_W-1:0]         o_count;
  logic                     o_sat;
  logic                     o_err;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit     m_open, m_satg, m_valid, m_sat_o, m_err;
  longint m_acc, m_res;
  int     m_cnt, m_cnt_o;

  psum_shift_accumulator #(.PSUM_W(PSUM_W), .SHIFT_W(SHIFT_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .i_psum(i_psum), .i_valid(i_valid), .o_in_ready(o_in_ready),
    .i_shift(i_shift), .i_first(i_first), .i_last(i_last), .o_result(o_result),
    .o_valid(o_valid), .i_out_ready(i_out_ready), .o_count(o_count), .o_sat(o_sat), .o_err(o_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // One clock edge with the current inputs; the model follows the behavioural rules.
  task automatic step();
    longint hi, lo, t, s;
    bit acc_b, pop, push, st, sb;
    int cnt;
    hi = (longint'(1) <<< (ACC_W-1)) - 1;
    lo = -(longint'(1) <<< (ACC_W-1));
    acc_b = i_valid && (!m_valid || i_out_ready);
    pop   = m_valid && i_out_ready;
    push  = acc_b && i_last;
    m_err = 1'b0;
    if (acc_b) begin
      st = i_first || !m_open;
      t  = longint'(i_psum) * (longint'(1) <<< i_shift);
      t  = t & ((longint'(1) <<< (ACC_W+1)) - 1);
      if (t >= (longint'(1) <<< ACC_W)) t = t - (longint'(1) <<< (ACC_W+1));
      s  = (st ? 0 : m_acc) + t;
      sb = (s > hi) || (s < lo);
      if (s > hi) s = hi;
      if (s < lo) s = lo;
      m_err = i_first ? m_open : !m_open;
      cnt   = st ? 1 : ((m_cnt + 1 > 255) ? 255 : m_cnt + 1);
      if (i_last) begin
        m_res = s; m_cnt_o = cnt; m_sat_o = (st ? 1'b0 : m_satg) | sb;
        m_valid = 1'b1; m_open = 1'b0; m_acc = 0; m_cnt = 0; m_satg = 1'b0;
      end else begin
        m_acc = s; m_cnt = cnt; m_satg = (st ? 1'b0 : m_satg) | sb; m_open = 1'b1;
      end
    end
    if (pop && !push) m_valid = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic beat(input int p, input int s, input bit f, input bit l);
    i_psum = PSUM_W'(p); i_shift = SHIFT_W'(s); i_first = f; i_last = l; i_valid = 1'b1;
    step();
    i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1; i_valid = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    m_open = 0; m_satg = 0; m_valid = 0; m_sat_o = 0; m_err = 0;
    m_acc = 0; m_res = 0; m_cnt = 0; m_cnt_o = 0;
  endtask

  task automatic test_reset();
    i_out_ready = 1'b1;
    do_reset();
    checks++; if ({o_valid, o_sat, o_err} !== 3'b000 || o_result !== '0 || o_count !== '0) begin
      errors++; $display("FAIL reset_outputs got v=%b s=%b e=%b r=%0d c=%0d exp all 0", o_valid, o_sat, o_err, o_result, o_count); end
    checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", o_in_ready); end
  endtask

  task automatic test_single_group();
    beat(3, 0, 1, 0);
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL grp_err got=%b exp=0", o_err); end
    beat(-2, 1, 0, 0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL grp_early_valid got=%b exp=0", o_valid); end
    beat(5, 2, 0, 1);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL grp_valid got=%b exp=1", o_valid); end
    checks++; if (o_result !== 12'(19)) begin errors++; $display("FAIL grp_result got=%0d exp=19", $signed(o_result)); end
    checks++; if (o_count !== 8'd3 || o_sat !== 1'b0) begin errors++; $display("FAIL grp_count_sat got=%0d/%b exp=3/0", o_count, o_sat); end
    step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL grp_valid_pop got=%b exp=0", o_valid); end
  endtask

  task automatic test_single_beat();
    beat(-128, 3, 1, 1);
    checks++; if (o_result !== 12'(-1024) || o_count !== 8'd1) begin
      errors++; $display("FAIL single_beat got=%0d/%0d exp=-1024/1", $signed(o_result), o_count); end
    step();
  endtask

  task automatic test_saturation();
    beat(127, 5, 1, 0);
    beat(127, 5, 0, 1);
    checks++; if (o_result !== 12'(2047) || o_sat !== 1'b1) begin
      errors++; $display("FAIL sat_result got=%0d/%b exp=2047/1", $signed(o_result), o_sat); end
    beat(1, 0, 1, 1);
    checks++; if (o_result !== 12'(1) || o_sat !== 1'b0) begin
      errors++; $display("FAIL sat_cleared got=%0d/%b exp=1/0", $signed(o_result), o_sat); end
    step();
  endtask

  task automatic test_backpressure();
    i_out_ready = 1'b0;
    beat(9, 0, 1, 1);
    step(); step();
    checks++; if (o_in_ready !== 1'b0 || o_valid !== 1'b1 || o_result !== 12'(9)) begin
      errors++; $display("FAIL bp_hold got=rdy%b v%b r%0d exp=rdy0 v1 r9", o_in_ready, o_valid, $signed(o_result)); end
    i_psum = 8'sd6; i_shift = '0; i_first = 1'b1; i_last = 1'b1; i_valid = 1'b1;
    step();
    checks++; if (o_result !== 12'(9)) begin errors++; $display("FAIL bp_no_accept got=%0d exp=9", $signed(o_result)); end
    i_out_ready = 1'b1;
    #1;
    checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_comb got=%b exp=1", o_in_ready); end
    step();
    i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0;
    checks++; if (o_valid !== 1'b1 || o_result !== 12'(6) || o_count !== 8'd1) begin
      errors++; $display("FAIL bp_pop_push got=v%b r%0d c%0d exp=v1 r6 c1", o_valid, $signed(o_result), o_count); end
    step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", o_valid); end
  endtask

  task automatic test_protocol_err();
    beat(10, 0, 1, 0);
    beat(4, 0, 1, 0);
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL perr_first_in_acc got=%b exp=1", o_err); end
    beat(0, 0, 0, 1);
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL perr_pulse_len got=%b exp=0", o_err); end
    checks++; if (o_result !== 12'(4) || o_count !== 8'd2) begin
      errors++; $display("FAIL perr_restart got=%0d/%0d exp=4/2", $signed(o_result), o_count); end
    beat(7, 0, 0, 1);
    checks++; if (o_err !== 1'b1 || o_result !== 12'(7) || o_count !== 8'd1) begin
      errors++; $display("FAIL perr_idle_nofirst got=e%b r%0d c%0d exp=e1 r7 c1", o_err, $signed(o_result), o_count); end
    step();
  endtask

  task automatic test_reset_mid();
    beat(5, 0, 1, 0);
    beat(6, 0, 0, 0);
    do_reset();
    checks++; if (o_valid !== 1'b0 || o_result !== '0 || o_count !== '0 || o_sat !== 1'b0 || o_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs got=v%b r%0d c%0d exp all 0", o_valid, o_result, o_count); end
    beat(1, 0, 1, 1);
    checks++; if (o_result !== 12'(1) || o_count !== 8'd1) begin
      errors++; $display("FAIL rstmid_after got=%0d/%0d exp=1/1", $signed(o_result), o_count); end
    step();
  endtask

  task automatic test_count_sat();
    beat(0, 0, 1, 0);
    for (int i = 0; i < 259; i++) beat(0, 0, 0, 0);
    beat(1, 0, 0, 1);
    checks++; if (o_count !== 8'd255 || o_result !== 12'(1)) begin
      errors++; $display("FAIL count_sat got=%0d/%0d exp=255/1", o_count, $signed(o_result)); end
    step();
  endtask

  task automatic test_random();
    bit acc_now;
    for (int n = 0; n < 500; n++) begin
      if (!i_valid && ($urandom_range(0, 9) < 7)) begin
        i_psum  = PSUM_W'($urandom_range(0, 255));
        i_shift = SHIFT_W'($urandom_range(0, 15));
        i_first = ($urandom_range(0, 4) == 0);
        i_last  = ($urandom_range(0, 3) == 0);
        i_valid = 1'b1;
      end
      i_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (o_in_ready !== (!m_valid || i_out_ready)) begin
        errors++; $display("FAIL rnd_in_ready n=%0d got=%b exp=%b", n, o_in_ready, !m_valid || i_out_ready); end
      acc_now = i_valid && (!m_valid || i_out_ready);
      step();
      if (acc_now) begin i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0; end
      checks++; if (o_valid !== m_valid || o_err !== m_err) begin
        errors++; $display("FAIL rnd_flags n=%0d got=v%b e%b exp=v%b e%b", n, o_valid, o_err, m_valid, m_err); end
      if (m_valid) begin
        checks++; if (o_result !== m_res[ACC_W-1:0] || o_count !== CNT_W'(m_cnt_o) || o_sat !== m_sat_o) begin
          errors++; $display("FAIL rnd_result n=%0d got=%0d/%0d/%b exp=%0d/%0d/%b", n,
                             $signed(o_result), o_count, o_sat, m_res, m_cnt_o, m_sat_o); end
      end
    end
    i_valid = 1'b0; i_out_ready = 1'b1;
    step();
  endtask

  initial begin
    @(posedge CLK); #1;
    test_reset();
    test_single_group();
    test_single_beat();
    test_saturation();
    test_backpressure();
    test_protocol_err();
    test_reset_mid();
    test_count_sat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
